npu_mmio_slave: RTL and testbench
=================================

NPU_MMIO_SLAVE -- requirements
Module: npu_mmio_slave

Interface
REQ-001 SHALL have parameter DWidth, default 32, meaning bus address/data width.
REQ-002 SHALL have parameter NumRegion, default 4, meaning number of decoded memory regions (1..8).
REQ-003 SHALL have parameter RegionWin, default 15, meaning log2 of region size in bytes.
REQ-004 SHALL have parameter BaseAddr, default 'h0000_8000, meaning byte address of region 0 (aligned to 2^RegionWin).
REQ-005 SHALL have parameter RdLatency, default 1, meaning cycles from ren_o to valid rdata_i (0..3).
REQ-006 SHALL have ports:
clk_i  in  1  clock, the only clock.
rst_ni  in  1  reset, asynchronous, active-low.
sel_i  in  1  slave select.
trans_i  in  2  transfer type (IDLE/BUSY/NONSEQ/SEQ).
ready_i  in  1  bus-wide ready.
write_i  in  1  1 = write.
addr_i  in  DWidth  byte address, address phase.
wdata_i  in  DWidth  write data, data phase.
rdata_i  in  NumRegion*DWidth  per-region read data, region k at slice k.
wen_o  out  NumRegion  one-hot region write enable.
ren_o  out  NumRegion  one-hot region read enable.
addr_o  out  DWidth  registered address, offset within region.
wdata_o  out  DWidth  equals wdata_i.
rdata_o  out  DWidth  read data to master.
resp_o  out  1  OKAY/ERROR.
ready_o  out  1  slave ready.

Function
REQ-007 SHALL accept an address phase when sel_i, ready_i high and trans_i is NONSEQ or SEQ; IDLE/BUSY SHALL be accepted as no-op (OKAY, zero wait).
REQ-008 SHALL decode region k when addr_i[DWidth-1:RegionWin] equals BaseAddr[DWidth-1:RegionWin]+k, k<NumRegion; otherwise unmapped.
REQ-009 SHALL register write_i, region index and addr_i[RegionWin-1:0] (zero-extended to addr_o) at acceptance.
REQ-010 States: IDLE, WRITE, READ, ERR1, ERR2; acceptance moves to WRITE/READ/ERR1 per write_i and decode.
REQ-011 WRITE: wen_o[k] high exactly one cycle, ready_o=1, resp_o=OKAY; next state per new acceptance that cycle, else IDLE.
REQ-012 READ: ren_o[k] high exactly the first data-phase cycle; ready_o low RdLatency cycles (2-bit counter), then high one cycle with rdata_o=rdata_i slice k; RdLatency=0 completes in the first cycle.
REQ-013 ERR1: resp_o=ERROR, ready_o=0; ERR2: resp_o=ERROR, ready_o=1; no wen_o/ren_o for unmapped accesses.
REQ-014 rdata_o SHALL hold the last completed read value outside read completion cycles.
REQ-015 Back-to-back: an address phase accepted in a completing cycle SHALL begin its data phase next cycle with no bubble; SEQ bursts sustain one write per cycle.
REQ-016 No acceptance while ready_o is low (ready_i low bus-wide).
REQ-017 wen_o and ren_o SHALL never both be non-zero.

Reset
REQ-018 rst_ni low SHALL asynchronously force IDLE, wen_o=ren_o=0, addr_o=0, rdata_o=0, resp_o=OKAY, ready_o=1, counter=0; mid-read reset discards the read.

Configuration
REQ-019 With NPU_MMIO_ERR_RESP_EN defined, unmapped accesses SHALL use ERR1/ERR2; without it, they SHALL complete in one cycle with OKAY, rdata_o=0, writes dropped, and ERR states are not built.

Structure
REQ-020 State enum, region index type, and OKAY/ERROR encodings SHALL live in a shared package pkg_npu_mmio (response/transfer encodings reused from the existing packages).
REQ-021 Address decode SHALL be a sub-module npu_mmio_decoder (addr in, hit flag and region index out); registers use the existing D_FF.

Verification
REQ-022 Write 'h1234 to BaseAddr+'h8004 (region 1) -> next cycle wen_o='b0010, addr_o='h4, wdata_o='h1234, ready_o=1.
REQ-023 Read region 2, RdLatency=2, rdata_i slice 2='hCAFE -> ren_o='b0100 one cycle, ready_o low 2 cycles, then rdata_o='hCAFE with ready_o=1.
REQ-024 Access to BaseAddr+4*2^RegionWin with macro defined -> ERROR/ready 0 then ERROR/ready 1; undefined -> OKAY, rdata_o=0, no enables.
REQ-025 SEQ burst of 4 writes to region 0 -> wen_o='b0001 for 4 consecutive cycles, addresses 0,4,8,'hC.
REQ-026 rst_ni low during read wait state -> immediate IDLE, ready_o=1, ren_o=0, no completion after release.

Source files
------------

// File: rtl/npu_mmio_slave_pkg.sv
// Shared types for the NPU MMIO slave: FSM states, region index type,
// bus transfer and response encodings, and a small transfer helper.
package pkg_npu_mmio;

  // Upper bound on decoded regions; the region index is sized for it.
  localparam int MaxRegion  = 8;
  localparam int RegionIdxW = 3;

  typedef logic [RegionIdxW-1:0] region_idx_t;

  // Bus transfer type encoding.
  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_BUSY   = 2'b01,
    TRANS_NONSEQ = 2'b10,
    TRANS_SEQ    = 2'b11
  } trans_e;

  // Bus response encoding.
  typedef enum logic {
    RESP_OKAY  = 1'b0,
    RESP_ERROR = 1'b1
  } resp_e;

  // Data-phase state of the slave.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_ERR1  = 3'd3,
    ST_ERR2  = 3'd4
  } state_e;

  // NONSEQ and SEQ carry a real access; IDLE and BUSY are no-ops.
  function automatic logic is_active_trans(logic [1:0] trans);
    return (trans == TRANS_NONSEQ) || (trans == TRANS_SEQ);
  endfunction

endpackage

// File: rtl/npu_mmio_slave_decoder.sv
// Region decoder: compares the address tag against the base tag and
// reports a hit plus the region index when the address falls in one of
// the NumRegion consecutive windows starting at BaseAddr.
module npu_mmio_decoder
  import pkg_npu_mmio::*;
#(
  parameter int                DWidth    = 32,
  parameter int                NumRegion = 4,
  parameter int                RegionWin = 15,
  parameter logic [DWidth-1:0] BaseAddr  = 'h0000_8000
) (
  input  logic [DWidth-1:0] addr_i,
  output logic              hit_o,
  output region_idx_t       region_o
);

  localparam int TagW = DWidth - RegionWin;
  localparam logic [TagW-1:0] BaseTag = BaseAddr[DWidth-1:RegionWin];
  localparam logic [TagW-1:0] NumTag  = TagW'(NumRegion);

  logic [TagW-1:0] tag_diff;

  // Addresses below the base wrap to a huge difference and miss.
  always_comb begin
    tag_diff = addr_i[DWidth-1:RegionWin] - BaseTag;
    hit_o    = (tag_diff < NumTag);
    region_o = tag_diff[RegionIdxW-1:0];
  end

endmodule

// File: rtl/npu_mmio_slave.sv
// NPU MMIO slave: accepts pipelined bus address phases, decodes them to
// one of NumRegion memory regions and drives one-hot write/read enables,
// inserting RdLatency wait states on reads.
// Optional feature macro: NPU_MMIO_ERR_RESP_EN -- when defined, unmapped
// accesses get a two-cycle ERROR response; otherwise they complete in one
// OKAY cycle with read data 0 and writes dropped.
module npu_mmio_slave
  import pkg_npu_mmio::*;
#(
  parameter int                DWidth    = 32,
  parameter int                NumRegion = 4,
  parameter int                RegionWin = 15,
  parameter logic [DWidth-1:0] BaseAddr  = 'h0000_8000,
  parameter int                RdLatency = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          sel_i,
  input  logic [1:0]                    trans_i,
  input  logic                          ready_i,
  input  logic                          write_i,
  input  logic [DWidth-1:0]             addr_i,
  input  logic [DWidth-1:0]             wdata_i,
  input  logic [NumRegion*DWidth-1:0]   rdata_i,
  output logic [NumRegion-1:0]          wen_o,
  output logic [NumRegion-1:0]          ren_o,
  output logic [DWidth-1:0]             addr_o,
  output logic [DWidth-1:0]             wdata_o,
  output logic [DWidth-1:0]             rdata_o,
  output logic                          resp_o,
  output logic                          ready_o
);

  localparam logic [1:0] RdLatCnt = 2'(RdLatency);

  // Registered state and outputs.
  state_e              state_q;
  logic [NumRegion-1:0] wen_q;
  logic [NumRegion-1:0] ren_q;
  logic [DWidth-1:0]   addr_q;
  logic [DWidth-1:0]   rdata_q;
  resp_e               resp_q;
  logic                ready_q;
  logic [1:0]          cnt_q;
  region_idx_t         region_q;

  // Address-phase decode and launch values.
  logic                 dec_hit;
  region_idx_t          dec_region;
  logic                 accept;
  logic [NumRegion-1:0] launch_oh;
  logic [DWidth-1:0]    offset;

  // Read data path.
  logic [DWidth-1:0]    rdata_arr [MaxRegion];
  logic [DWidth-1:0]    rdata_sel;
  logic                 rd_done;

  npu_mmio_decoder #(
    .DWidth   (DWidth),
    .NumRegion(NumRegion),
    .RegionWin(RegionWin),
    .BaseAddr (BaseAddr)
  ) u_decoder (
    .addr_i  (addr_i),
    .hit_o   (dec_hit),
    .region_o(dec_region)
  );

  // Unpack the per-region read buses; unused region slots read as zero so
  // the full-width region index can select without range issues.
  for (genvar gi = 0; gi < MaxRegion; gi++) begin : g_rdata
    if (gi < NumRegion) begin : g_used
      assign rdata_arr[gi] = rdata_i[gi*DWidth +: DWidth];
    end else begin : g_unused
      assign rdata_arr[gi] = '0;
    end
  end

  // One-hot enable for the region being decoded in the address phase.
  for (genvar gi = 0; gi < NumRegion; gi++) begin : g_onehot
    assign launch_oh[gi] = (dec_region == region_idx_t'(gi));
  end

  // A new access is taken only while the current data phase completes.
  always_comb begin
    accept    = sel_i && ready_i && ready_q && is_active_trans(trans_i);
    offset    = {{(DWidth-RegionWin){1'b0}}, addr_i[RegionWin-1:0]};
    rdata_sel = rdata_arr[region_q];
    rd_done   = (state_q == ST_READ) && ready_q;
  end

  // Data-phase FSM with registered enables, address, response and ready.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      wen_q    <= '0;
      ren_q    <= '0;
      addr_q   <= '0;
      rdata_q  <= '0;
      resp_q   <= RESP_OKAY;
      ready_q  <= 1'b1;
      cnt_q    <= '0;
      region_q <= '0;
    end else begin
      // Enables are single-cycle pulses unless relaunched below.
      wen_q <= '0;
      ren_q <= '0;
      // Remember the value handed to the master on read completion.
      if (rd_done) begin
        rdata_q <= rdata_sel;
      end

      if ((state_q == ST_READ) && !ready_q) begin
        // Read wait states: ready rises when the counter runs out.
        cnt_q   <= cnt_q - 2'd1;
        ready_q <= (cnt_q == 2'd1);
      end
`ifdef NPU_MMIO_ERR_RESP_EN
      else if (state_q == ST_ERR1) begin
        state_q <= ST_ERR2;
        resp_q  <= RESP_ERROR;
        ready_q <= 1'b1;
      end
`endif
      else if (accept) begin
        addr_q   <= offset;
        region_q <= dec_region;
        if (dec_hit && write_i) begin
          state_q <= ST_WRITE;
          wen_q   <= launch_oh;
          resp_q  <= RESP_OKAY;
          ready_q <= 1'b1;
        end else if (dec_hit) begin
          state_q <= ST_READ;
          ren_q   <= launch_oh;
          resp_q  <= RESP_OKAY;
          cnt_q   <= RdLatCnt;
          ready_q <= (RdLatency == 0);
        end else begin
`ifdef NPU_MMIO_ERR_RESP_EN
          state_q <= ST_ERR1;
          resp_q  <= RESP_ERROR;
          ready_q <= 1'b0;
`else
          // Unmapped: the idle outputs already form an OKAY zero-wait
          // completion; a read returns zero by clearing the held data.
          state_q <= ST_IDLE;
          resp_q  <= RESP_OKAY;
          ready_q <= 1'b1;
          if (!write_i) begin
            rdata_q <= '0;
          end
`endif
        end
      end else begin
        state_q <= ST_IDLE;
        resp_q  <= RESP_OKAY;
        ready_q <= 1'b1;
      end
    end
  end

  // Read data is live only in the completing cycle, held otherwise.
  always_comb begin
    rdata_o = rd_done ? rdata_sel : rdata_q;
  end

  assign wen_o   = wen_q;
  assign ren_o   = ren_q;
  assign addr_o  = addr_q;
  assign wdata_o = wdata_i;
  assign resp_o  = resp_q;
  assign ready_o = ready_q;

endmodule

// File: tb/tb_npu_mmio_slave.sv
// Testbench for npu_mmio_slave: table of per-cycle vectors plus hand
// sequences for a SEQ write burst and reset during a read wait state.
module tb_npu_mmio_slave;
  import pkg_npu_mmio::*;

  localparam int          DW   = 32;
  localparam int          NR   = 4;
  localparam int          RW   = 15;
  localparam logic [31:0] BASE = 32'h0000_8000;
  localparam int          RL   = 2;

`ifdef NPU_MMIO_ERR_RESP_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  localparam logic [1:0] TI = 2'b00;
  localparam logic [1:0] TB = 2'b01;
  localparam logic [1:0] TN = 2'b10;
  localparam logic [1:0] TS = 2'b11;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             sel = 1'b0;
  logic [1:0]       trans = 2'b00;
  logic             ready_i;
  logic             write = 1'b0;
  logic [DW-1:0]    addr = '0;
  logic [DW-1:0]    wdata = '0;
  logic [NR*DW-1:0] rdata_i;
  logic [NR-1:0]    wen_o;
  logic [NR-1:0]    ren_o;
  logic [DW-1:0]    addr_o;
  logic [DW-1:0]    wdata_o;
  logic [DW-1:0]    rdata_o;
  logic             resp_o;
  logic             ready_o;

  always #5 clk = ~clk;

  // Single slave on the bus: bus-wide ready is this slave's ready.
  assign ready_i = ready_o;
  assign rdata_i = {32'h4444_0003, 32'h0000_CAFE, 32'h2222_0001, 32'h1111_0000};

  npu_mmio_slave #(
    .DWidth   (DW),
    .NumRegion(NR),
    .RegionWin(RW),
    .BaseAddr (BASE),
    .RdLatency(RL)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .sel_i  (sel),
    .trans_i(trans),
    .ready_i(ready_i),
    .write_i(write),
    .addr_i (addr),
    .wdata_i(wdata),
    .rdata_i(rdata_i),
    .wen_o  (wen_o),
    .ren_o  (ren_o),
    .addr_o (addr_o),
    .wdata_o(wdata_o),
    .rdata_o(rdata_o),
    .resp_o (resp_o),
    .ready_o(ready_o)
  );

  typedef struct packed {
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  exp_wen;
    logic [3:0]  exp_ren;
    logic [31:0] exp_addr;
    logic [31:0] exp_rdata;
    logic        exp_resp;
    logic        exp_ready;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic s, input logic [1:0] t, input logic w,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] ew, input logic [3:0] er,
                     input logic [31:0] ea, input logic [31:0] erd,
                     input logic eresp, input logic erdy);
    vec_t v;
    v = '{s, t, w, a, d, ew, er, ea, erd, eresp, erdy};
    vecs.push_back(v);
  endtask

  task automatic drive(input logic s, input logic [1:0] t, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    sel   = s;
    trans = t;
    write = w;
    addr  = a;
    wdata = d;
  endtask

  logic [31:0] rd_unm;
  logic        resp_unm;
  logic        rdy_unm1;

  initial begin
    // Held read data after the unmapped read: zero, or the old value when
    // the ERROR response path is built.
    rd_unm   = ErrEn ? 32'h0000_CAFE : 32'h0;
    resp_unm = ErrEn ? RESP_ERROR : RESP_OKAY;
    rdy_unm1 = ErrEn ? 1'b0 : 1'b1;

    //  sel trans wr  addr          wdata         wen   ren   addr_o   rdata_o        resp       ready
    add(0, TI, 0, 32'h0,       32'h0,        4'h0, 4'h0, 32'h0,  32'h0,         RESP_OKAY, 1);   // 0 idle
    add(1, TN, 1, 32'h0001_0004, 32'h0,      4'h0, 4'h0, 32'h0,  32'h0,         RESP_OKAY, 1);   // 1 write r1
    add(0, TI, 0, 32'h0,       32'h1234,     4'h2, 4'h0, 32'h4,  32'h0,         RESP_OKAY, 1);   // 2 data phase
    add(1, TI, 0, 32'h0,       32'h0,        4'h0, 4'h0, 32'h4,  32'h0,         RESP_OKAY, 1);   // 3 IDLE no-op
    add(1, TB, 0, 32'h0,       32'h0,        4'h0, 4'h0, 32'h4,  32'h0,         RESP_OKAY, 1);   // 4 BUSY no-op
    add(1, TN, 0, 32'h0001_8010, 32'h0,      4'h0, 4'h0, 32'h4,  32'h0,         RESP_OKAY, 1);   // 5 read r2
    add(0, TI, 0, 32'h0,       32'h0,        4'h0, 4'h4, 32'h10, 32'h0,         RESP_OKAY, 0);   // 6 ren pulse
    add(1, TN, 1, 32'h0000_8008, 32'h0,      4'h0, 4'h0, 32'h10, 32'h0,         RESP_OKAY, 0);   // 7 ignored
    add(0, TI, 0, 32'h0,       32'h0,        4'h0, 4'h0, 32'h10, 32'h0000_CAFE, RESP_OKAY, 1);   // 8 complete
    add(0, TI, 0, 32'h0,       32'h0,        4'h0, 4'h0, 32'h10, 32'h0000_CAFE, RESP_OKAY, 1);   // 9 hold
    add(1, TN, 0, 32'h0002_8000, 32'h0,      4'h0, 4'h0, 32'h10, 32'h0000_CAFE, RESP_OKAY, 1);   // 10 unmapped rd
    add(0, TI, 0, 32'h0,       32'h0,        4'h0, 4'h0, 32'h0,  rd_unm,        resp_unm,  rdy_unm1);
    add(0, TI, 0, 32'h0,       32'h0,        4'h0, 4'h0, 32'h0,  rd_unm,        resp_unm,  1);   // 12
    add(1, TN, 1, 32'h0002_8004, 32'h0,      4'h0, 4'h0, 32'h0,  rd_unm,        RESP_OKAY, 1);   // 13 unmapped wr
    add(0, TI, 0, 32'h0,       32'h99,       4'h0, 4'h0, 32'h4,  rd_unm,        resp_unm,  rdy_unm1);
    add(0, TI, 0, 32'h0,       32'h0,        4'h0, 4'h0, 32'h4,  rd_unm,        resp_unm,  1);   // 15
    add(1, TN, 1, 32'h0000_8020, 32'h0,      4'h0, 4'h0, 32'h4,  rd_unm,        RESP_OKAY, 1);   // 16 write r0
    add(1, TN, 0, 32'h0002_0008, 32'h55AA,   4'h1, 4'h0, 32'h20, rd_unm,        RESP_OKAY, 1);   // 17 wr + rd r3
    add(0, TI, 0, 32'h0,       32'h0,        4'h0, 4'h8, 32'h8,  rd_unm,        RESP_OKAY, 0);   // 18
    add(0, TI, 0, 32'h0,       32'h0,        4'h0, 4'h0, 32'h8,  rd_unm,        RESP_OKAY, 0);   // 19
    add(1, TN, 1, 32'h0001_0008, 32'h0,      4'h0, 4'h0, 32'h8,  32'h4444_0003, RESP_OKAY, 1);   // 20 rd done + wr
    add(0, TI, 0, 32'h0,       32'h77,       4'h2, 4'h0, 32'h8,  32'h4444_0003, RESP_OKAY, 1);   // 21
    add(0, TI, 0, 32'h0,       32'h0,        4'h0, 4'h0, 32'h8,  32'h4444_0003, RESP_OKAY, 1);   // 22

    // Reset state, observed while reset is held.
    drive(0, TI, 0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset.wen",   32'(wen_o),   32'h0);
    check("reset.ren",   32'(ren_o),   32'h0);
    check("reset.addr",  addr_o,       32'h0);
    check("reset.rdata", rdata_o,      32'h0);
    check("reset.resp",  32'(resp_o),  32'(RESP_OKAY));
    check("reset.ready", 32'(ready_o), 32'h1);
    rst_n = 1'b1;

    // Table: inputs applied after the edge, outputs sampled mid-cycle.
    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      drive(vecs[i].sel, vecs[i].trans, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      @(negedge clk);
      $display("vec %0d: sel=%0d trans=%0d wr=%0d addr=%h | wen=%b ren=%b addr_o=%h rdata_o=%h resp=%0d ready=%0d",
               i, sel, trans, write, addr, wen_o, ren_o, addr_o, rdata_o, resp_o, ready_o);
      check($sformatf("v%0d.wen", i),   32'(wen_o),   32'(vecs[i].exp_wen));
      check($sformatf("v%0d.ren", i),   32'(ren_o),   32'(vecs[i].exp_ren));
      check($sformatf("v%0d.addr", i),  addr_o,       vecs[i].exp_addr);
      check($sformatf("v%0d.rdata", i), rdata_o,      vecs[i].exp_rdata);
      check($sformatf("v%0d.resp", i),  32'(resp_o),  32'(vecs[i].exp_resp));
      check($sformatf("v%0d.ready", i), 32'(ready_o), 32'(vecs[i].exp_ready));
      check($sformatf("v%0d.wdata", i), wdata_o,      vecs[i].wdata);
      check($sformatf("v%0d.excl", i),  32'((wen_o != '0) && (ren_o != '0)), 32'h0);
    end

    // SEQ burst of four writes to region 0: one wen per cycle, no bubble.
    for (int i = 0; i < 6; i++) begin
      logic [31:0] exp_a;
      @(posedge clk);
      #1;
      if (i == 0)      drive(1, TN, 1, BASE, 32'h0);
      else if (i < 4)  drive(1, TS, 1, BASE + 32'(4 * i), 32'hB0 + 32'(i - 1));
      else if (i == 4) drive(0, TI, 0, 32'h0, 32'hB3);
      else             drive(0, TI, 0, 32'h0, 32'h0);
      exp_a = (i == 0) ? 32'h8 : ((i <= 4) ? 32'(4 * (i - 1)) : 32'hC);
      @(negedge clk);
      $display("burst %0d: wen=%b addr_o=%h ready=%0d", i, wen_o, addr_o, ready_o);
      check($sformatf("burst%0d.wen", i),   32'(wen_o),   ((i >= 1) && (i <= 4)) ? 32'h1 : 32'h0);
      check($sformatf("burst%0d.addr", i),  addr_o,       exp_a);
      check($sformatf("burst%0d.ready", i), 32'(ready_o), 32'h1);
    end

    // Reset in a read wait state: read is discarded, no late completion.
    @(posedge clk);
    #1;
    drive(1, TN, 0, 32'h0001_000C, 32'h0);
    @(posedge clk);
    #1;
    drive(0, TI, 0, 32'h0, 32'h0);
    @(negedge clk);
    check("rstrd.ren_pulse", 32'(ren_o), 32'h2);
    @(negedge clk);
    check("rstrd.wait", 32'(ready_o), 32'h0);
    rst_n = 1'b0;
    #1;
    $display("rst mid-read: ready=%0d ren=%b addr_o=%h rdata_o=%h", ready_o, ren_o, addr_o, rdata_o);
    check("rstrd.ready", 32'(ready_o), 32'h1);
    check("rstrd.ren",   32'(ren_o),   32'h0);
    check("rstrd.addr",  addr_o,       32'h0);
    check("rstrd.rdata", rdata_o,      32'h0);
    check("rstrd.resp",  32'(resp_o),  32'(RESP_OKAY));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      $display("post-rst %0d: ready=%0d ren=%b wen=%b rdata_o=%h", i, ready_o, ren_o, wen_o, rdata_o);
      check($sformatf("postrst%0d.ready", i), 32'(ready_o), 32'h1);
      check($sformatf("postrst%0d.rdata", i), rdata_o,      32'h0);
      check($sformatf("postrst%0d.en", i),    32'({wen_o, ren_o}), 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
